// File: rtl/program_loader.sv
// program_loader: boot-time loader that receives a length-prefixed,
// XOR-checksummed byte stream and writes it as 16-bit words into memory.
// The processor is held in reset until a complete image with a good checksum
// has been stored.
module program_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 1024
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_LEN_HI = 3'd0,
        S_LEN_LO = 3'd1,
        S_W_HI   = 3'd2,
        S_W_LO   = 3'd3,
        S_WR     = 3'd4,
        S_CHK    = 3'd5,
        S_RUN    = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [7:0]          hi_q, hi_d;
    logic [7:0]          xor_q, xor_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]         mem_data_q, mem_data_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                xfer_s;
    logic [15:0]         len_rx_s;
    logic [15:0]         addr_full_s;
    logic [15:0]         cnt_inc_s;

    // Byte acceptance is a pure decode of the registered state.
    always_comb begin
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_W_HI, S_W_LO, S_CHK: in_ready = 1'b1;
            default:                                   in_ready = 1'b0;
        endcase
    end

    assign xfer_s      = in_valid & in_ready;
    assign len_rx_s    = {len_q[15:8], in_data};
    assign addr_full_s = 16'(BASE_ADDR) + cnt_q;
    assign cnt_inc_s   = cnt_q + 16'd1;

    // Next-state and next-output logic; registered outputs are computed one cycle ahead.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        hi_d        = hi_q;
        xor_d       = xor_q;
        cnt_d       = cnt_q;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            S_LEN_HI: begin
                if (xfer_s) begin
                    len_d[15:8] = in_data;
                    xor_d       = xor_q ^ in_data;
                    state_d     = S_LEN_LO;
                end else begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_LO: begin
                if (xfer_s) begin
                    len_d[7:0] = in_data;
                    xor_d      = xor_q ^ in_data;
                    if ({1'b0, len_rx_s} > 17'(MAX_WORDS)) begin
                        state_d     = S_ERR;
                        error_d     = 1'b1;
                        cpu_reset_d = 1'b1;
                    end else if (len_rx_s == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_W_HI;
                    end
                end else begin
                    state_d = S_LEN_LO;
                end
            end
            S_W_HI: begin
                if (xfer_s) begin
                    hi_d    = in_data;
                    xor_d   = xor_q ^ in_data;
                    state_d = S_W_LO;
                end else begin
                    state_d = S_W_HI;
                end
            end
            S_W_LO: begin
                // Strobe, data and address are staged here so they appear registered in WR.
                if (xfer_s) begin
                    xor_d       = xor_q ^ in_data;
                    mem_write_d = 1'b1;
                    mem_data_d  = {hi_q, in_data};
                    mem_addr_d  = addr_full_s[ADDR_W-1:0];
                    state_d     = S_WR;
                end else begin
                    state_d = S_W_LO;
                end
            end
            S_WR: begin
                cnt_d = cnt_inc_s;
                if (cnt_inc_s == len_q) begin
                    state_d = S_CHK;
                end else begin
                    state_d = S_W_HI;
                end
            end
            S_CHK: begin
                if (xfer_s) begin
                    if (in_data == xor_q) begin
                        state_d     = S_RUN;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d     = S_ERR;
                        error_d     = 1'b1;
                        cpu_reset_d = 1'b1;
                    end
                end else begin
                    state_d = S_CHK;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d     = S_ERR;
                error_d     = 1'b1;
                cpu_reset_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset that outranks all inputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_LEN_HI;
            len_q       <= 16'd0;
            hi_q        <= 8'd0;
            xor_q       <= 8'd0;
            cnt_q       <= 16'd0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= ADDR_W'(BASE_ADDR);
            mem_data_q  <= 16'd0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            hi_q        <= hi_d;
            xor_q       <= xor_d;
            cnt_q       <= cnt_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader. Expected memory
// writes are queued as bytes are driven and popped by a write monitor.
module tb_program_loader;

    localparam int ADDR_W    = 10;
    localparam int BASE_ADDR = 0;
    localparam int MAX_WORDS = 1024;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic              cpu_reset;
    logic              done;
    logic              error;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_count = 0;

    logic [31:0] exp_q[$];      // {addr(16), data(16)}
    logic [15:0] img[16];

    program_loader #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .CLK      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .cpu_reset(cpu_reset),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            wr_count++;
            check_eq("wr_in_ready_low", {31'd0, in_ready}, 32'd0);
            check_eq("wr_cpu_reset_high", {31'd0, cpu_reset}, 32'd1);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", {16'(mem_addr), mem_data}, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check_eq("wr_addr", 32'(mem_addr), {16'd0, e[31:16]});
                check_eq("wr_data", 32'(mem_data), {16'd0, e[15:0]});
            end
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one byte, optionally after a random idle gap; returns at the negedge after the transfer.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int budget;
        if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        budget   = 0;
        while (in_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            check_eq("ready_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Stream a complete image of n words from img[]; the checksum byte is corrupted if bad_chk.
    task automatic load_image(input int n, input bit bad_chk, input int gap_max);
        logic [7:0] chk;
        logic [15:0] nn;
        nn  = 16'(n);
        chk = nn[15:8] ^ nn[7:0];
        send_byte(nn[15:8], gap_max);
        send_byte(nn[7:0], gap_max);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({16'(BASE_ADDR + i), img[i]});
            chk = chk ^ img[i][15:8] ^ img[i][7:0];
            send_byte(img[i][15:8], gap_max);
            send_byte(img[i][7:0], gap_max);
        end
        repeat (2) @(negedge clk);
        check_eq("cpu_reset_before_chk", {31'd0, cpu_reset}, 32'd1);
        check_eq("done_before_chk", {31'd0, done}, 32'd0);
        send_byte(bad_chk ? ~chk : chk, gap_max);
    endtask

    initial begin
        int w0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        do_reset();

        // Reset values
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'(BASE_ADDR));
        check_eq("rst_mem_data", 32'(mem_data), 32'd0);
        check_eq("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_error", {31'd0, error}, 32'd0);

        // T1: two-word good image; cpu_reset falls one cycle after CHK
        img[0] = 16'h1234;
        img[1] = 16'hABCD;
        w0 = wr_count;
        load_image(2, 1'b0, 0);
        check_eq("t1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check_eq("t1_done", {31'd0, done}, 32'd1);
        check_eq("t1_error", {31'd0, error}, 32'd0);
        check_eq("t1_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("t1_writes", 32'(wr_count - w0), 32'd2);
        check_eq("t1_sb_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("t1_done_sticky", {31'd0, done}, 32'd1);

        // T2: bad checksum
        do_reset();
        check_eq("t2_rst_mem_data", 32'(mem_data), 32'd0);
        w0 = wr_count;
        load_image(2, 1'b1, 0);
        check_eq("t2_error", {31'd0, error}, 32'd1);
        check_eq("t2_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_eq("t2_done", {31'd0, done}, 32'd0);
        check_eq("t2_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("t2_writes", 32'(wr_count - w0), 32'd2);
        check_eq("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // T3: empty image
        do_reset();
        w0 = wr_count;
        load_image(0, 1'b0, 0);
        check_eq("t3_done", {31'd0, done}, 32'd1);
        check_eq("t3_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check_eq("t3_writes", 32'(wr_count - w0), 32'd0);

        // T4: oversized length
        do_reset();
        w0 = wr_count;
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        check_eq("t4_error", {31'd0, error}, 32'd1);
        check_eq("t4_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("t4_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        repeat (3) @(negedge clk);
        check_eq("t4_done", {31'd0, done}, 32'd0);
        check_eq("t4_writes", 32'(wr_count - w0), 32'd0);

        // T5: four random words with random valid gaps
        do_reset();
        for (int i = 0; i < 4; i++) img[i] = 16'($urandom);
        w0 = wr_count;
        load_image(4, 1'b0, 3);
        check_eq("t5_done", {31'd0, done}, 32'd1);
        check_eq("t5_error", {31'd0, error}, 32'd0);
        check_eq("t5_writes", 32'(wr_count - w0), 32'd4);
        check_eq("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // T6: reset mid-load after one word, then a fresh one-word image
        do_reset();
        img[0] = 16'h5A5A;
        w0 = wr_count;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        exp_q.push_back({16'(BASE_ADDR), img[0]});
        send_byte(img[0][15:8], 0);
        send_byte(img[0][7:0], 0);
        @(negedge clk);
        check_eq("t6_first_write", 32'(wr_count - w0), 32'd1);
        check_eq("t6_cpu_reset_mid", {31'd0, cpu_reset}, 32'd1);
        do_reset();
        check_eq("t6_cpu_reset_rst", {31'd0, cpu_reset}, 32'd1);
        check_eq("t6_in_ready_rst", {31'd0, in_ready}, 32'd1);
        img[0] = 16'hC3E1;
        load_image(1, 1'b0, 0);
        check_eq("t6_done", {31'd0, done}, 32'd1);
        check_eq("t6_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check_eq("t6_writes", 32'(wr_count - w0), 32'd2);
        check_eq("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
